bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Sequences ownership of a shared N-driver internal 8-bit bus. Grants one requester at a time
//  (round-robin), drives the bus's driver_enables and pull_down_enables inputs, and inserts a
//  one-cycle turnaround between owners so two drivers are never enabled together.
//  A hold watchdog forces release from stuck owners. Sits beside the bus, between it and the
//  control sequencer.
// PARAMETERS
//  N         4   number of requesters/drivers (>=2); must equal the N of the controlled bus
//  MAX_HOLD  8   max consecutive GRANT cycles before forced release (>=2)
// PORTS
//  clk                input   1          single clock; all state on rising edge
//  rst_n              input   1          asynchronous, active-low reset
//  req                input   [N-1:0]    bus request, level, one bit per requester
//  lock               input   [N-1:0]    owner's bit high: watchdog disabled for that owner
//  pd_mask            input   [N-1:0][7:0] per-requester pull-down mask applied while granted
//  err_clr            input   1          clears timeout_err (sync, 1-cycle pulse)
//  driver_enables     output  [N-1:0]    one-hot or zero; registered; to bus driver_enables
//  pull_down_enables  output  [7:0]      pd_mask[grant_id] in GRANT, else 8'h00; registered
//  grant_id           output  [$clog2(N)-1:0] index of current owner (valid only with grant_valid)
//  grant_valid        output  1          high in GRANT
//  timeout_err        output  1          sticky; set on watchdog release
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, driver_enables=0, pull_down_enables=0, grant_id=0,
//    grant_valid=0, timeout_err=0, hold_cnt=0, rr pointer last=N-1 (so requester 0 wins first).
//  - States: IDLE, GRANT, TURN.
//  - IDLE: any req -> GRANT next cycle; winner = first set bit searching last+1 upward, wrapping.
//    Latency: req high at edge t -> driver_enables one-hot after edge t+1. No req: stay IDLE.
//  - GRANT: owner=grant_id; hold_cnt increments each cycle (saturating at MAX_HOLD).
//    * req[owner]=0 -> TURN; last<=owner.
//    * watchdog: hold_cnt==MAX_HOLD-1, lock[owner]=0 and any other req bit set -> TURN,
//      last<=owner, timeout_err<=1. Without other requesters no release and no error.
//    * else stay; pd_mask is sampled every GRANT cycle (mask changes follow 1 cycle later).
//  - TURN: exactly one cycle, driver_enables=0, pull_down_enables=0, grant_valid=0, hold_cnt<=0.
//    Then: any req -> GRANT with rr pick from updated last (an owner still requesting after
//    forced release ranks last); else IDLE.
//  - Never grant-to-grant directly; every owner change passes through TURN.
//  - Request dropped during the IDLE->GRANT edge: grant still issued for 1 cycle, then TURN.
//  - err_clr and a new watchdog event in the same cycle: set wins (timeout_err stays 1).
//  - Reset asserted mid-GRANT: all outputs go to reset values immediately (asynchronous),
//    no turnaround cycle is owed.
//  - Outputs are all registered; no combinational path from req/lock/pd_mask to outputs.
// STRUCTURE
//  - bus_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;
//    localparam BUS_W=8; shared with bus and future sequencer blocks.
//  - Sub-module rr_pick #(N): combinational; inputs req, last; outputs found, idx.
//    Instantiated once; arbiter holds state, counters and output registers.
// TESTING
//  1 Reset: rst_n low with req=4'hF -> all outputs 0; release -> IDLE until next edge.
//  2 Single: req=4'b0100 at edge t -> driver_enables=4'b0100, grant_id=2 after t+1; drop req
//    -> one TURN cycle with enables=0, then IDLE.
//  3 RR order: req=4'b1011 held, each owner drops after 2 cycles -> owners 0,1,3 with a zero
//    enable cycle between each; never two enable bits set (assert $onehot0 every cycle).
//  4 Watchdog: req=4'b0011 held, owner 0 never drops, MAX_HOLD=8 -> release after 8 GRANT
//    cycles, TURN, owner 1 granted, timeout_err=1 until err_clr pulse.
//  5 Lock: same as 4 with lock[0]=1 -> owner 0 kept indefinitely (>=3*MAX_HOLD), timeout_err=0.
//  6 Pull-down + async reset: pd_mask[1]=8'hA5, grant 1 -> pull_down_enables=8'hA5; assert
//    rst_n mid-grant between edges -> enables and pd drop to 0 before next clk edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: data width and arbiter state encoding.
package bus_pkg;
  localparam int BUS_W = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit searching from last+1 upward, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);
  int            c;
  logic [IW-1:0] ci;

  // Walk the ring starting just after the previous owner; first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      c  = (int'(last) + k) % N;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared internal bus, with a mandatory
// one-cycle turnaround between owners and a hold watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic [N-1:0]              lock,
  input  logic [N-1:0][BUS_W-1:0]   pd_mask,
  input  logic                      err_clr,
  output logic [N-1:0]              driver_enables,
  output logic [BUS_W-1:0]          pull_down_enables,
  output logic [IW-1:0]             grant_id,
  output logic                      grant_valid,
  output logic                      timeout_err
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [N-1:0]      en_q, en_d;
  logic [BUS_W-1:0]  pd_q, pd_d;
  logic              gv_q, gv_d;
  logic              err_q, err_d;
  logic              wd_fire;
  logic [N-1:0]      owner_oh;
  logic [N-1:0]      others;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    owner_oh   = N'(1) << gid_q;
    others     = req & ~owner_oh;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    gid_d      = gid_q;
    en_d       = '0;
    pd_d       = '0;
    gv_d       = 1'b0;
    wd_fire    = 1'b0;
    case (state_q)
      ARB_GRANT: begin
        if (!req[gid_q]) begin
          state_d = ARB_TURN;
          last_d  = gid_q;
        end else if (hold_cnt_q == HOLD_LIM && !lock[gid_q] && |others) begin
          // Forced release: the stuck owner ranks last on the next pick.
          state_d = ARB_TURN;
          last_d  = gid_q;
          wd_fire = 1'b1;
        end else begin
          en_d = owner_oh;
          pd_d = pd_mask[gid_q];
          gv_d = 1'b1;
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and TURN both pick from the current pointer; TURN has already
        // spent its single dead cycle by the time this edge lands.
        hold_cnt_d = '0;
        if (pick_found) begin
          state_d = ARB_GRANT;
          gid_d   = pick_idx;
          en_d    = N'(1) << pick_idx;
          pd_d    = pd_mask[pick_idx];
          gv_d    = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
    endcase
    // A watchdog event in the same cycle as err_clr keeps the flag set.
    err_d = (err_q & ~err_clr) | wd_fire;
  end

  // State and registered outputs; async reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      hold_cnt_q <= '0;
      last_q     <= IW'(N - 1);
      gid_q      <= '0;
      en_q       <= '0;
      pd_q       <= '0;
      gv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      gid_q      <= gid_d;
      en_q       <= en_d;
      pd_q       <= pd_d;
      gv_q       <= gv_d;
      err_q      <= err_d;
    end
  end

  assign driver_enables    = en_q;
  assign pull_down_enables = pd_q;
  assign grant_id          = gid_q;
  assign grant_valid       = gv_q;
  assign timeout_err       = err_q;
endmodule
